// File: rtl/ldm_stm_reg_sequencer.sv
// Block-transfer register sequencer: walks the captured LDM/STM register list
// and presents one register number per beat, ascending or descending.
module ldm_stm_reg_sequencer #(
    parameter int LIST_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LIST_W-1:0] reg_list,
    input  logic              up,
    input  logic              ack,
    output logic [ADDR_W-1:0] reg_num,
    output logic              valid,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  beat
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        state;
    logic [LIST_W-1:0] pending;
    logic              dir;
    logic [ADDR_W-1:0] lo_idx, hi_idx, sel_idx;
    logic [CNT_W-1:0]  list_pop;
    logic              one_left;
    logic              issuing;

    // Lowest and highest set bit of the registered pending list.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--)
            if (pending[i]) lo_idx = ADDR_W'(i);
        for (int i = 0; i < LIST_W; i++)
            if (pending[i]) hi_idx = ADDR_W'(i);
    end

    always_comb begin
        list_pop = '0;
        for (int i = 0; i < LIST_W; i++)
            list_pop = list_pop + CNT_W'(reg_list[i]);
    end

    assign sel_idx  = dir ? lo_idx : hi_idx;
    assign one_left = (pending != '0) && ((pending & (pending - LIST_W'(1))) == '0);
    assign issuing  = (state == S_ISSUE);

    assign valid   = issuing;
    assign reg_num = issuing ? sel_idx : '0;
    assign last    = issuing && one_left;
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pending <= '0;
            dir     <= 1'b0;
            count   <= '0;
            beat    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending <= reg_list;
                        dir     <= up;
                        count   <= list_pop;
                        beat    <= '0;
                        state   <= (reg_list != '0) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (ack) begin
                        pending <= pending & ~(LIST_W'(1) << sel_idx);
                        beat    <= beat + CNT_W'(1);
                        if (one_left) state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_reg_sequencer.sv
// Bench for ldm_stm_reg_sequencer: directed scenarios plus random lists, checked
// against an expected-order queue built from the register list.
module tb_ldm_stm_reg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] reg_list = '0;
    logic        up = 1'b0;
    logic        ack = 1'b0;
    logic [3:0]  reg_num;
    logic        valid, last, busy, done;
    logic [4:0]  count, beat;

    int vectors = 0;
    int miscompares = 0;

    ldm_stm_reg_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .reg_list(reg_list), .up(up),
        .ack(ack), .reg_num(reg_num), .valid(valid), .last(last), .busy(busy),
        .done(done), .count(count), .beat(beat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; outputs are checked at negedges, inputs change there.
    task automatic run_seq(input logic [15:0] lst, input logic dir, input int ack_pct,
                           input bit extra_start);
        int q[$];
        int pc, beat_m, stall, guard;
        bit a;
        q = {};
        for (int i = 0; i < 16; i++)
            if (lst[i]) begin
                if (dir) q.push_back(i);
                else q.push_front(i);
            end
        pc = q.size();
        chk("idle_busy", busy, 0);
        start = 1'b1; reg_list = lst; up = dir;
        @(negedge clk);
        start = 1'b0;
        beat_m = 0; stall = 0; guard = 0;
        while (q.size() > 0 && guard < 200) begin
            guard++;
            chk("valid", valid, 1);
            chk("reg_num", reg_num, q[0]);
            chk("last", last, q.size() == 1);
            chk("busy", busy, 1);
            chk("done_lo", done, 0);
            chk("beat", beat, beat_m);
            chk("count", count, pc);
            a = ($urandom_range(99) < ack_pct) || (stall >= 4);
            ack = a;
            reg_list = 16'($urandom);
            up = 1'($urandom);
            if (extra_start && beat_m == 1) begin
                start = 1'b1; reg_list = 16'h0001;
            end
            @(negedge clk);
            start = 1'b0;
            if (a) begin
                void'(q.pop_front());
                beat_m++;
                stall = 0;
            end else stall++;
        end
        chk("seq_bound", guard < 200, 1);
        ack = 1'($urandom);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", valid, 0);
        chk("done_beat", beat, pc);
        chk("done_count", count, pc);
        @(negedge clk);
        ack = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_count", count, pc);
    endtask

    initial begin
        logic [15:0] l;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_beat", beat, 0);
        chk("rst_regnum", reg_num, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(16'h8005, 1'b1, 100, 0);
        run_seq(16'h8005, 1'b0, 100, 0);
        run_seq(16'h0000, 1'b1, 100, 0);
        run_seq(16'h0012, 1'b1, 0, 0);
        run_seq(16'hFFFF, 1'b1, 100, 1);

        // Reset mid-sequence after two acks
        start = 1'b1; reg_list = 16'h00F0; up = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rs_first", reg_num, 4);
        ack = 1'b1;
        @(negedge clk);
        chk("rs_second", reg_num, 5);
        @(negedge clk);
        ack = 1'b0;
        chk("rs_third", reg_num, 6);
        rst_n = 1'b0;
        #1;
        chk("rs_valid", valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_count", count, 0);
        chk("rs_beat", beat, 0);
        chk("rs_regnum", reg_num, 0);
        @(negedge clk);
        chk("rs_nodone", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_idle_done", done, 0);
        run_seq(16'h00F0, 1'b1, 100, 0);

        for (int k = 0; k < 25; k++) begin
            l = 16'($urandom);
            if (k % 3 == 0) l = l & 16'($urandom) & 16'($urandom);
            run_seq(l, 1'($urandom), 60, k % 4 == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
